// File: rtl/mem_test_engine.sv
// Host-side SDRAM exerciser: writes a seeded pattern over an address window
// through the FIFOs, reads it back in order and reports mismatches.
module mem_test_engine #(
   parameter int                     HADDR_WIDTH     = 24,
   parameter logic [HADDR_WIDTH-1:0] START_ADDR      = 24'h000000,
   parameter int                     NUM_WORDS       = 256,
   parameter logic [15:0]            PATTERN_SEED    = 16'hA5C3,
   parameter int                     MAX_OUTSTANDING = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   busy,
   output logic [HADDR_WIDTH-1:0] haddr,
   output logic                   wr_enable,
   output logic [15:0]            wr_data,
   output logic                   rd_enable,
   input  logic [15:0]            rd_data,
   input  logic                   rd_rdy,
   output logic                   rd_ack,
   output logic                   running,
   output logic                   done,
   output logic                   pass,
   output logic [7:0]             err_count,
   output logic [HADDR_WIDTH-1:0] first_err_addr
);

   localparam int CW = HADDR_WIDTH + 1;
   localparam logic [CW-1:0] NUM  = CW'(NUM_WORDS);
   localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);
   localparam logic [CW-1:0] C_ONE = CW'(1);
   localparam logic [HADDR_WIDTH-1:0] A_ONE = HADDR_WIDTH'(1);
   localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]             state;
   logic                   start_q;
   logic [HADDR_WIDTH-1:0] wr_addr;
   logic [HADDR_WIDTH-1:0] rd_addr;
   logic [HADDR_WIDTH-1:0] chk_addr;
   logic [CW-1:0]          wr_cnt;
   logic [CW-1:0]          iss_cnt;
   logic [CW-1:0]          chk_cnt;
   logic [3:0]             outstanding;

   logic        start_rise;
   logic        can_write;
   logic        can_issue;
   logic        take;
   logic        check;
   logic        mismatch;
   logic [15:0] expect_data;

   function automatic logic [15:0] pattern(input logic [15:0] a);
      return a ^ PATTERN_SEED;
   endfunction

   // A word is taken only when rd_ack is low, so pops never run back to back.
   always_comb begin
      start_rise  = start & ~start_q;
      can_write   = (state == S_WRITE) & ~busy;
      can_issue   = (state == S_READ) & ~busy &
                    (outstanding < MAXO) & (iss_cnt < NUM);
      take        = rd_rdy & ~rd_ack;
      check       = take & (state == S_READ);
      expect_data = pattern(chk_addr[15:0]);
      mismatch    = check & (rd_data != expect_data);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         start_q        <= 1'b0;
         wr_addr        <= '0;
         rd_addr        <= '0;
         chk_addr       <= '0;
         wr_cnt         <= '0;
         iss_cnt        <= '0;
         chk_cnt        <= '0;
         outstanding    <= '0;
         haddr          <= '0;
         wr_enable      <= 1'b0;
         wr_data        <= '0;
         rd_enable      <= 1'b0;
         rd_ack         <= 1'b0;
         running        <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         start_q   <= start;
         wr_enable <= 1'b0;
         rd_enable <= 1'b0;
         rd_ack    <= take;

         case ({can_issue, check})
            2'b10:   outstanding <= outstanding + 4'd1;
            2'b01:   outstanding <= outstanding - 4'd1;
            default: ;
         endcase

         case (state)
            S_WRITE: begin
               if (can_write) begin
                  wr_enable <= 1'b1;
                  haddr     <= wr_addr;
                  wr_data   <= pattern(wr_addr[15:0]);
                  wr_addr   <= wr_addr + A_ONE;
                  wr_cnt    <= wr_cnt + C_ONE;
                  if (wr_cnt == LAST)
                     state <= S_READ;
               end
            end
            S_READ: begin
               if (can_issue) begin
                  rd_enable <= 1'b1;
                  haddr     <= rd_addr;
                  rd_addr   <= rd_addr + A_ONE;
                  iss_cnt   <= iss_cnt + C_ONE;
               end
               if (mismatch) begin
                  if (err_count != 8'hFF)
                     err_count <= err_count + 8'd1;
                  if (err_count == 8'd0)
                     first_err_addr <= chk_addr;
               end
               if (check) begin
                  chk_addr <= chk_addr + A_ONE;
                  chk_cnt  <= chk_cnt + C_ONE;
                  if (chk_cnt == LAST) begin
                     state   <= S_DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
                     pass    <= (err_count == 8'd0) & ~mismatch;
                  end
               end
            end
            default: begin
               // IDLE and DONE: only drain via rd_ack, or launch a new run
               if (start_rise) begin
                  state          <= S_WRITE;
                  running        <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  wr_addr        <= START_ADDR;
                  rd_addr        <= START_ADDR;
                  chk_addr       <= START_ADDR;
                  wr_cnt         <= '0;
                  iss_cnt        <= '0;
                  chk_cnt        <= '0;
                  outstanding    <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_test_engine.sv
// Scoreboard bench for mem_test_engine: FIFO/memory model per instance,
// expected transactions queued by the stimulus and popped by monitors.
module tb_mem_test_engine;

   localparam int AW = 24;

   typedef struct {
      logic [AW-1:0] a;
      logic [15:0]   d;
   } wr_t;

   typedef struct {
      logic [7:0]    e;
      logic [AW-1:0] f;
      logic          p;
   } res_t;

   typedef struct {
      logic [AW-1:0] a;
      int            due;
   } pend_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] start_v = 2'b00;
   logic [1:0] done_v;

   wr_t           exp_wr[$];
   logic [AW-1:0] exp_rd[$];
   res_t          exp_res[$];

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int start_cyc = 0;
   int lat = 0;
   int delay = 0;
   int busy_after = -1;
   int n_wr = 0;
   int n_rd = 0;
   int n_ack = 0;
   int tb_out = 0;
   int max_out = 0;
   int iss_before_ack = 0;
   logic acked = 1'b0;
   logic corrupt_all = 1'b0;
   logic bad_en = 1'b0;
   logic [AW-1:0] bad_addr = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam logic [AW-1:0] SA = (g == 0) ? 24'h000000 : 24'hFFFFFE;
      localparam int NW = (g == 0) ? 4 : 300;

      logic          busy = 1'b0;
      logic          rd_rdy = 1'b0;
      logic [15:0]   rd_data = 16'h0;
      logic [AW-1:0] haddr;
      logic [AW-1:0] first_err_addr;
      logic [15:0]   wr_data;
      logic          wr_enable;
      logic          rd_enable;
      logic          rd_ack;
      logic          running;
      logic          done;
      logic          pass;
      logic [7:0]    err_count;
      logic [15:0]   mem [logic [AW-1:0]];
      pend_t         pend[$];
      logic [15:0]   fifo[$];
      int            busy_left = 0;
      logic          busy_s = 1'b0;
      logic          ack_q = 1'b0;
      logic          done_q = 1'b0;

      mem_test_engine #(
         .HADDR_WIDTH(AW),
         .START_ADDR(SA),
         .NUM_WORDS(NW),
         .PATTERN_SEED(16'hA5C3),
         .MAX_OUTSTANDING(4)
      ) dut (
         .clk(clk),
         .rst_n(rst_n),
         .start(start_v[g]),
         .busy(busy),
         .haddr(haddr),
         .wr_enable(wr_enable),
         .wr_data(wr_data),
         .rd_enable(rd_enable),
         .rd_data(rd_data),
         .rd_rdy(rd_rdy),
         .rd_ack(rd_ack),
         .running(running),
         .done(done),
         .pass(pass),
         .err_count(err_count),
         .first_err_addr(first_err_addr)
      );

      assign done_v[g] = done;
      always @(posedge clk) busy_s <= busy;

      always @(negedge clk) begin : mon
         wr_t           w;
         res_t          r;
         pend_t         p;
         logic [15:0]   d;
         logic [AW-1:0] ra;
         if (busy_s)
            chk("strobe_while_busy", {30'd0, wr_enable, rd_enable}, 32'd0);
         if (wr_enable) begin
            n_wr++;
            if (n_wr == 1) lat = cyc - start_cyc;
            chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
               w = exp_wr.pop_front();
               chk("wr_addr", 32'(haddr), 32'(w.a));
               chk("wr_data", 32'(wr_data), 32'(w.d));
            end
         end
         if (rd_ack) begin
            n_ack++;
            acked = 1'b1;
            tb_out--;
            chk("ack_gap", 32'(ack_q), 32'd0);
            chk("ack_has_data", 32'(fifo.size() != 0), 32'd1);
            if (fifo.size() != 0) void'(fifo.pop_front());
         end
         ack_q = rd_ack;
         if (rd_enable) begin
            n_rd++;
            tb_out++;
            if (!acked) iss_before_ack++;
            if (tb_out > max_out) max_out = tb_out;
            chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) begin
               ra = exp_rd.pop_front();
               chk("rd_addr", 32'(haddr), 32'(ra));
            end
            pend.push_back('{haddr, cyc + delay});
         end
         if (done && !done_q) begin
            chk("res_expected", 32'(exp_res.size() != 0), 32'd1);
            if (exp_res.size() != 0) begin
               r = exp_res.pop_front();
               chk("res_err_count", 32'(err_count), 32'(r.e));
               chk("res_first_err", 32'(first_err_addr), 32'(r.f));
               chk("res_pass", 32'(pass), 32'(r.p));
            end
         end
         done_q = done;
         if (wr_enable) mem[haddr] = wr_data;
         while (pend.size() != 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            d = mem.exists(p.a) ? mem[p.a] : 16'h0;
            if (corrupt_all || (bad_en && p.a == bad_addr))
               d = d ^ 16'h0001;
            fifo.push_back(d);
         end
         rd_rdy = fifo.size() != 0;
         rd_data = rd_rdy ? fifo[0] : 16'h0;
         if (busy_left > 0) busy_left--;
         if (wr_enable && n_wr == busy_after) busy_left = 3;
         busy = busy_left > 0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_haddr"}, 32'(u[0].haddr), 32'd0);
      chk({tag, "_wr_data"}, 32'(u[0].wr_data), 32'd0);
      chk({tag, "_flags"}, {26'd0, u[0].wr_enable, u[0].rd_enable,
          u[0].rd_ack, u[0].running, u[0].done, u[0].pass}, 32'd0);
      chk({tag, "_err_count"}, 32'(u[0].err_count), 32'd0);
      chk({tag, "_first_err"}, 32'(u[0].first_err_addr), 32'd0);
   endtask

   task automatic push_win4();
      exp_wr.push_back('{24'h000000, 16'hA5C3});
      exp_wr.push_back('{24'h000001, 16'hA5C2});
      exp_wr.push_back('{24'h000002, 16'hA5C1});
      exp_wr.push_back('{24'h000003, 16'hA5C0});
      for (int i = 0; i < 4; i++) exp_rd.push_back(AW'(i));
   endtask

   task automatic run(input int g, input int budget);
      int k;
      tb_out = 0;
      max_out = 0;
      iss_before_ack = 0;
      acked = 1'b0;
      n_wr = 0;
      tick();
      start_v[g] = 1'b1;
      start_cyc = cyc;
      tick();
      tick();
      k = 0;
      while (!done_v[g] && k < budget) begin
         tick();
         k++;
      end
      chk("run_done", 32'(done_v[g]), 32'd1);
      chk("start_latency", lat, 2);
      repeat (6) tick();
      chk("done_held", 32'(done_v[g]), 32'd1);
      start_v[g] = 1'b0;
      chk("writes_left", exp_wr.size(), 0);
      chk("reads_left", exp_rd.size(), 0);
   endtask

   initial begin : stim
      logic [AW-1:0] a;
      int k;
      rst_n = 1'b0;
      repeat (3) tick();
      check_reset("reset");
      rst_n = 1'b1;
      tick();

      push_win4();
      exp_res.push_back('{8'd0, 24'h0, 1'b1});
      run(0, 200);

      busy_after = 2;
      push_win4();
      exp_res.push_back('{8'd0, 24'h0, 1'b1});
      run(0, 200);
      busy_after = -1;

      bad_en = 1'b1;
      bad_addr = 24'h000002;
      push_win4();
      exp_res.push_back('{8'd1, 24'h000002, 1'b0});
      run(0, 200);
      bad_en = 1'b0;

      delay = 50;
      push_win4();
      exp_res.push_back('{8'd0, 24'h0, 1'b1});
      run(0, 500);
      chk("issues_before_ack", iss_before_ack, 4);
      chk("max_outstanding", max_out, 4);

      push_win4();
      n_rd = 0;
      tick();
      start_v[0] = 1'b1;
      start_cyc = cyc;
      k = 0;
      while (n_rd < 3 && k < 100) begin
         tick();
         k++;
      end
      chk("reads_before_reset", n_rd, 3);
      rst_n = 1'b0;
      start_v[0] = 1'b0;
      #1;
      check_reset("midrun");
      exp_rd.delete();
      n_ack = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (70) tick();
      chk("late_acks", n_ack, 3);
      chk("late_err_count", 32'(u[0].err_count), 32'd0);
      chk("late_done", 32'(u[0].done), 32'd0);
      chk("late_fifo_empty", 32'(u[0].rd_rdy), 32'd0);
      delay = 0;
      push_win4();
      exp_res.push_back('{8'd0, 24'h0, 1'b1});
      run(0, 200);

      corrupt_all = 1'b1;
      exp_wr.push_back('{24'hFFFFFE, 16'h5A3D});
      exp_wr.push_back('{24'hFFFFFF, 16'h5A3C});
      exp_wr.push_back('{24'h000000, 16'hA5C3});
      for (int i = 3; i < 300; i++) begin
         a = 24'hFFFFFE + AW'(i);
         exp_wr.push_back('{a, a[15:0] ^ 16'hA5C3});
      end
      for (int i = 0; i < 300; i++) exp_rd.push_back(24'hFFFFFE + AW'(i));
      exp_res.push_back('{8'hFF, 24'hFFFFFE, 1'b0});
      run(1, 3000);
      corrupt_all = 1'b0;

      repeat (4) tick();
      chk("results_left", exp_res.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
